// File: rtl/m_uxa_ps2_linefifo_pkg.sv
// Shared constants for the UXA PS/2 line FIFO: read-word bit positions and idle line level.
// Imported by the RTL, the bus controller and the software header generator.
package m_uxa_ps2_linefifo_pkg;

  localparam int unsigned QBitValid = 15;
  localparam int unsigned QBitOvf   = 14;
  localparam int unsigned QBitC     = 9;
  localparam int unsigned QBitD     = 8;

  localparam logic [1:0] LineIdle = 2'b11;

endpackage

// File: rtl/m_uxa_ps2_sync2.sv
// One-bit two-flop synchroniser for an asynchronous pin, with a configurable reset level.
module m_uxa_ps2_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= ResetVal;
      sync2_q <= ResetVal;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/m_uxa_ps2_linefifo.sv
// PS/2 line sampler: synchronises C/D, queues every change of the {C,D} pair and presents
// the oldest entry plus valid/overflow flags as a 16-bit read word.
module m_uxa_ps2_linefifo
  import m_uxa_ps2_linefifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          sys_clk_i,
  input  logic          sys_reset_i,
  input  logic          ps2_c_i,
  input  logic          ps2_d_i,
  input  logic          rp_inc_i,
  output logic [15:0]   q_o,
  output logic [AW:0]   level_o
);

  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic       c_sync, d_sync;
  logic [1:0] cd_sync;

  m_uxa_ps2_sync2 #(.ResetVal(1'b1)) u_sync_c (
    .clk_i (sys_clk_i),
    .rst_i (sys_reset_i),
    .d_i   (ps2_c_i),
    .q_o   (c_sync)
  );

  m_uxa_ps2_sync2 #(.ResetVal(1'b1)) u_sync_d (
    .clk_i (sys_clk_i),
    .rst_i (sys_reset_i),
    .d_i   (ps2_d_i),
    .q_o   (d_sync)
  );

  assign cd_sync = {c_sync, d_sync};

  logic [1:0]  last_cd_q, last_cd_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  mem_q [DEPTH];

  logic push, pop, wr_en, empty, full;
  logic [1:0] head;

  assign push  = (cd_sync != last_cd_q);
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop   = rp_inc_i && !empty;
  // A full FIFO still takes the sample when a pop frees a slot in the same cycle.
  assign wr_en = push && (!full || pop);

  always_comb begin
    last_cd_d = last_cd_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    ovf_d     = ovf_q;
    if (push) last_cd_d = cd_sync;
    if (wr_en) wp_d = wp_q + PtrOne;
    if (pop) rp_d = rp_q + PtrOne;
    if (rp_inc_i) ovf_d = 1'b0;
    // Set after clear so a dropped sample wins over a same-cycle pop request.
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_reset_i) begin
      last_cd_q <= LineIdle;
      wp_q      <= '0;
      rp_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      last_cd_q <= last_cd_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (wr_en) mem_q[wp_q[AW-1:0]] <= cd_sync;
  end

  assign head = empty ? LineIdle : mem_q[rp_q[AW-1:0]];

  always_comb begin
    q_o            = '0;
    q_o[QBitValid] = !empty;
    q_o[QBitOvf]   = ovf_q;
    q_o[QBitC]     = head[1];
    q_o[QBitD]     = head[0];
  end

  assign level_o = wp_q - rp_q;

endmodule

// File: tb/tb_m_uxa_ps2_linefifo.sv
// Randomised and directed bench for m_uxa_ps2_linefifo against a queue-based reference model.
module tb_m_uxa_ps2_linefifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_c = 1'b1, ps2_d = 1'b1, rp_inc = 1'b0;
  logic [15:0]   q;
  logic [AW:0]   level;

  m_uxa_ps2_linefifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sys_clk_i   (clk),
    .sys_reset_i (rst),
    .ps2_c_i     (ps2_c),
    .ps2_d_i     (ps2_d),
    .rp_inc_i    (rp_inc),
    .q_o         (q),
    .level_o     (level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: pins as seen at the last two edges, last queued pair, queue, overflow.
  logic [1:0] pin_hist1 = 2'b11, pin_hist2 = 2'b11;
  logic [1:0] m_last = 2'b11;
  logic [1:0] mq[$];
  logic       m_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_q();
    logic [15:0] w;
    w = '0;
    w[15] = (mq.size() != 0);
    w[14] = m_ovf;
    w[9:8] = (mq.size() != 0) ? mq[0] : 2'b11;
    return w;
  endfunction

  task automatic model_edge();
    logic [1:0] cand;
    bit was_full, popped;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_last = 2'b11;
      pin_hist1 = 2'b11;
      pin_hist2 = 2'b11;
      return;
    end
    cand = pin_hist2;
    was_full = (mq.size() == DEPTH);
    popped = 0;
    if (rp_inc) begin
      m_ovf = 1'b0;
      if (mq.size() != 0) begin
        void'(mq.pop_front());
        popped = 1;
      end
    end
    if (cand != m_last) begin
      m_last = cand;
      if (!was_full || popped) mq.push_back(cand);
      else m_ovf = 1'b1;
    end
    pin_hist2 = pin_hist1;
    pin_hist1 = {ps2_c, ps2_d};
  endtask

  task automatic step(input logic c, input logic d, input logic p, input logic r);
    ps2_c = c;
    ps2_d = d;
    rp_inc = p;
    rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("q_o", q, model_q());
    check_eq("level_o", 16'(level), 16'(mq.size()));
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(ps2_c, ps2_d, 1'b0, 1'b0);
  endtask

  task automatic drain();
    hold(3);
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) step(ps2_c, ps2_d, 1'b1, 1'b0);
    step(ps2_c, ps2_d, 1'b1, 1'b0);
  endtask

  task automatic toggle_c_n(input int n);
    for (int i = 0; i < n; i++) begin
      step(~ps2_c, ps2_d, 1'b0, 1'b0);
      hold(1);
    end
    hold(3);
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("reset_q", q, 16'h0300);
    check_eq("reset_level", 16'(level), 16'd0);

    hold(20);
    check_eq("idle_q", q, 16'h0300);
    check_eq("idle_level", 16'(level), 16'd0);

    // Single change: C low captured at edge N, queued at N+2.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    hold(1);
    check_eq("single_pre_level", 16'(level), 16'd0);
    hold(1);
    check_eq("single_level", 16'(level), 16'd1);
    check_eq("single_q", q, 16'h8100);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("single_pop_q", q, 16'h0300);
    check_eq("single_pop_level", 16'(level), 16'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // PS/2 frame: D changes together with C falling, 11 bits -> 22 entries.
    for (int b = 0; b < 11; b++) begin
      step(1'b0, b[0], 1'b0, 1'b0);
      hold(1);
      step(1'b1, ps2_d, 1'b0, 1'b0);
      hold(1);
    end
    hold(3);
    check_eq("frame_level", 16'(level), 16'd16);
    check_eq("frame_ovf", 16'(q[14]), 16'd1);
    drain();

    for (int b = 0; b < 5; b++) begin
      step(1'b0, b[0], 1'b0, 1'b0);
      hold(1);
      step(1'b1, ps2_d, 1'b0, 1'b0);
      hold(1);
    end
    hold(3);
    check_eq("frame10_level", 16'(level), 16'd10);
    drain();

    // Overflow: 17 changes without pops.
    toggle_c_n(17);
    check_eq("ovf_level", 16'(level), 16'd16);
    check_eq("ovf_flag", 16'(q[14]), 16'd1);
    step(ps2_c, ps2_d, 1'b1, 1'b0);
    check_eq("ovf_pop_flag", 16'(q[14]), 16'd0);
    check_eq("ovf_pop_level", 16'(level), 16'd15);
    drain();

    // Full with a push and pop in the same cycle.
    toggle_c_n(16);
    check_eq("full_level", 16'(level), 16'd16);
    step(~ps2_c, ps2_d, 1'b0, 1'b0);
    hold(1);
    step(ps2_c, ps2_d, 1'b1, 1'b0);
    check_eq("fullpop_level", 16'(level), 16'd16);
    check_eq("fullpop_ovf", 16'(q[14]), 16'd0);
    drain();

    // Empty pop, then reset with entries queued.
    step(ps2_c, ps2_d, 1'b1, 1'b0);
    check_eq("empty_pop_level", 16'(level), 16'd0);
    toggle_c_n(5);
    check_eq("pre_reset_level", 16'(level), 16'd5);
    step(ps2_c, ps2_d, 1'b0, 1'b1);
    check_eq("mid_reset_q", q, 16'h0300);
    check_eq("mid_reset_level", 16'(level), 16'd0);
    hold(4);

    // Random pins, pops and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic nc, nd, np, nr;
      nc = ps2_c;
      nd = ps2_d;
      if ($urandom_range(3) == 0) nc = ~nc;
      if ($urandom_range(3) == 0) nd = ~nd;
      np = ($urandom_range(2) == 0);
      nr = ($urandom_range(499) == 0);
      step(nc, nd, np, nr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
